// File: rtl/div_ctrl.sv
// div_ctrl: iterative radix-2 restoring divider controller for the EX stage (DIV / DIVU).
// One quotient bit is produced per cycle; the pipeline is stalled while the divide is busy.
//
// Ports:
//   clk              - clock, all state updates on the rising edge
//   rst              - asynchronous active-high reset
//   start_i          - divide request, held high by EX until ready_o is seen
//   signed_div_i     - 1 = DIV (signed), 0 = DIVU
//   annul_i          - cancel the in-flight divide (pipeline flush)
//   opdata1_i        - dividend, sampled only on accept
//   opdata2_i        - divisor, sampled only on accept
//   result_o         - {remainder, quotient} = {hi, lo}
//   ready_o          - result valid
//   stallreq_for_div - stall request towards the pipeline control
module div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_for_div
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StDivZero, StOn, StEnd} state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [CntW-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_neg_quo;
  logic               r_neg_rem;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_op1_abs;
  logic [WIDTH-1:0]   w_op2_abs;
  logic [WIDTH:0]     w_upper;
  logic [WIDTH:0]     w_diff;
  logic               w_fits;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_quo_fix;

  assign w_accept = (r_state == StIdle) && start_i && !annul_i;
  assign w_last   = (r_state == StOn) && (r_cnt == CntW'(WIDTH - 1));

  // Magnitudes are only taken for signed divides; -MIN wraps to MIN, which is
  // still the correct unsigned magnitude.
  assign w_op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // Shift {rem, quo} left by one and trial-subtract from the top WIDTH+1 bits.
  // rem < divisor always holds, so bit WIDTH of the difference is a valid borrow.
  assign w_upper    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_upper - {1'b0, r_divisor};
  assign w_fits     = !w_diff[WIDTH];
  assign w_rem_next = w_fits ? w_diff[WIDTH-1:0] : w_upper[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};

  // Sign fix-up: quotient negative iff operand signs differ, remainder follows dividend.
  assign w_quo_fix = r_neg_quo ? -w_quo_next : w_quo_next;
  assign w_rem_fix = r_neg_rem ? -w_rem_next : w_rem_next;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = (opdata2_i == '0) ? StDivZero : StOn;
        end
      end
      StDivZero: w_state_next = StEnd;
      StOn: begin
        if (annul_i) begin
          w_state_next = StIdle;
        end else if (w_last) begin
          w_state_next = StEnd;
        end
      end
      StEnd: begin
        if (annul_i || !start_i) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    stallreq_for_div = w_accept || (r_state == StDivZero) || (r_state == StOn);
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept && (opdata2_i != '0)) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= w_op1_abs;
            r_divisor <= w_op2_abs;
            r_neg_quo <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_neg_rem <= signed_div_i && opdata1_i[WIDTH-1];
          end
        end
        StDivZero: begin
          r_result <= '0;
          r_ready  <= 1'b1;
        end
        StOn: begin
          // On annul the partial data is simply left behind; the next accept reloads it.
          if (!annul_i) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_result <= {w_rem_fix, w_quo_fix};
              r_ready  <= 1'b1;
            end
          end
        end
        StEnd: begin
          if (annul_i || !start_i) begin
            r_result <= '0;
            r_ready  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] res;
    int          lat;
    int          hold;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vec[12];

  div_ctrl #(.WIDTH(32)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start),
    .signed_div_i     (signed_div),
    .annul_i          (annul),
    .opdata1_i        (opdata1),
    .opdata2_i        (opdata2),
    .result_o         (result),
    .ready_o          (ready),
    .stallreq_for_div (stallreq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called just after a falling edge. Drives one divide, waits for ready_o and
  // compares against the scoreboard; optionally holds start_i in END for 'hold' cycles.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] exp_res, input int exp_lat, input int hold);
    exp_t e;
    exp_t g;
    int   cyc;
    bit   got;
    bit   stall_ok;
    bit   hold_ok;
    e.res = exp_res;
    e.lat = exp_lat;
    sb.push_back(e);
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    start      = 1'b1;
    #1 stall_ok = (stallreq === 1'b1);
    cyc = 0;
    got = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      // Operands must be ignored once accepted.
      opdata1 = $urandom;
      opdata2 = $urandom;
      if (ready === 1'b1) got = 1;
      else if (stallreq !== 1'b1) stall_ok = 0;
    end
    check("ready_seen", 64'(got), 64'd1);
    g = sb.pop_front();
    check("latency", 64'(cyc), 64'(g.lat));
    check("result", result, g.res);
    check("stall_while_busy", 64'(stall_ok), 64'd1);
    check("stall_in_end", 64'(stallreq), 64'd0);
    if (hold > 0) begin
      hold_ok = 1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (ready !== 1'b1 || result !== g.res || stallreq !== 1'b0) hold_ok = 0;
      end
      check("end_hold", 64'(hold_ok), 64'd1);
    end
    start = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(ready), 64'd0);
    check("idle_result", result, 64'd0);
  endtask

  initial begin
    bit              ok;
    bit              got;
    logic [31:0]     ra;
    logic [31:0]     rb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;

    vec[0]  = '{32'd100,       32'd7,          1'b0, {32'h00000002, 32'h0000000E}, 33, 0};
    vec[1]  = '{32'hFFFFFFF9,  32'h00000002,   1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0};
    vec[2]  = '{32'd7,         32'hFFFFFFFE,   1'b1, {32'h00000001, 32'hFFFFFFFD}, 33, 0};
    vec[3]  = '{32'd5,         32'd0,          1'b0, 64'd0,                        2,  0};
    vec[4]  = '{32'h80000000,  32'hFFFFFFFF,   1'b1, {32'h00000000, 32'h80000000}, 33, 0};
    vec[5]  = '{32'hFFFFFFFF,  32'd1,          1'b0, {32'h00000000, 32'hFFFFFFFF}, 33, 0};
    vec[6]  = '{32'hFFFFFFF9,  32'hFFFFFFFE,   1'b1, {32'hFFFFFFFF, 32'h00000003}, 33, 3};
    vec[7]  = '{32'hFFFFFFF9,  32'd2,          1'b0, {32'h00000001, 32'h7FFFFFFC}, 33, 0};
    vec[8]  = '{32'd1,         32'hFFFFFFFF,   1'b0, {32'h00000001, 32'h00000000}, 33, 0};
    vec[9]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,   1'b0, {32'h00000000, 32'h00000001}, 33, 0};
    vec[10] = '{32'h80000000,  32'd3,          1'b1, {32'hFFFFFFFE, 32'hD5555556}, 33, 0};
    vec[11] = '{32'hFFFFFFF9,  32'd0,          1'b1, 64'd0,                        2,  2};

    // Reset state
    #1 rst = 1'b1;
    #3;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_stall", 64'(stallreq), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vec[i]) begin
      run_div(vec[i].a, vec[i].b, vec[i].sgn, vec[i].res, vec[i].lat, vec[i].hold);
    end

    // Random vectors against a native-arithmetic reference
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (rb == 0) rb = 32'd3;
      if (i[0]) begin
        if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) ra = 32'd1;
        sq = $signed(ra) / $signed(rb);
        sr = $signed(ra) % $signed(rb);
        run_div(ra, rb, 1'b1, {sr, sq}, 33, 0);
      end else begin
        run_div(ra, rb, 1'b0, {ra % rb, ra / rb}, 33, 0);
      end
    end

    // start with annul in IDLE must not be accepted (divisor 0 would give ready at cycle 2)
    opdata1 = 32'd5;
    opdata2 = 32'd0;
    signed_div = 1'b0;
    start = 1'b1;
    annul = 1'b1;
    #1 check("annul_idle_stall", 64'(stallreq), 64'd0);
    @(negedge clk);
    start = 1'b0;
    annul = 1'b0;
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready !== 1'b0 || stallreq !== 1'b0) ok = 0;
    end
    check("annul_idle_no_accept", 64'(ok), 64'd1);

    // Annul in ON cycle 10, then a new divide two cycles later
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    start = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    check("annul_on_stall", 64'(stallreq), 64'd0);
    ok = 1;
    for (int i = 0; i < 2; i++) begin
      if (ready !== 1'b0 || result !== 64'd0) ok = 0;
      @(negedge clk);
    end
    check("annul_on_no_ready", 64'(ok), 64'd1);
    run_div(32'd20, 32'd3, 1'b0, {32'd2, 32'd6}, 33, 0);

    // Asynchronous reset mid-ON
    opdata1 = 32'd9;
    opdata2 = 32'd4;
    start = 1'b1;
    repeat (6) @(negedge clk);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_on_ready", 64'(ready), 64'd0);
    check("rst_on_result", result, 64'd0);
    check("rst_on_stall", 64'(stallreq), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_rst_stall", 64'(stallreq), 64'd0);
    run_div(32'd20, 32'd3, 1'b0, {32'd2, 32'd6}, 33, 0);

    // Asynchronous reset while in END with a result presented
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    start = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (ready === 1'b1) got = 1;
    end
    check("end_rst_ready_seen", 64'(got), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_end_ready", 64'(ready), 64'd0);
    check("rst_end_result", result, 64'd0);
    start = 1'b0;
    #1 check("rst_end_stall", 64'(stallreq), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_end_idle_ready", 64'(ready), 64'd0);

    if (sb.size() != 0) check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
